mux2t1_32_arb: RTL
==================

# mux2t1_32_arb

Two-requester round-robin arbiter and sequencer for the 32-bit 2:1 data multiplexer `MUX2T1_32`. It owns that mux's select line, grants the shared 32-bit path to one requester at a time with a valid/ready handshake, and caps how long one requester can hold the grant. The selected word is registered into a single-entry output stage toward the downstream consumer.

## Interface
- `MAX_BURST`, default 4: maximum consecutive transfers from one requester while the other is waiting; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `I0` in 32: requester 0 data.
- `v0` in 1: requester 0 valid.
- `r0` out 1: requester 0 ready.
- `I1` in 32: requester 1 data.
- `v1` in 1: requester 1 valid.
- `r1` out 1: requester 1 ready.
- `s` out 1: current mux select (registered); 0 = `I0`, 1 = `I1`.
- `o` out 32: registered output data.
- `ov` out 1: output valid.
- `ordy` in 1: downstream ready.

## Operation
- States:
  - IDLE: no grant.
  - G0: requester 0 granted.
  - G1: requester 1 granted.
- `s` = 1 only in G1.
- Slot free: `free = !ov || ordy`.
- Ready outputs: `r0 = (state==G0) && free`, `r1 = (state==G1) && free`. Both are combinational from registered state; both are 0 in IDLE.
- Transfer on requester i: `vi && ri`. On a transfer:
  - `o <=` mux output.
  - `ov <= 1`.
  - `cnt <= cnt+1`.
- Output drain: if `ov && ordy` with no transfer that cycle, `ov <= 0`, and `o` holds its value.
- Pointer `last` records the most recently served requester; it updates on entry to G0 or G1.
- IDLE transitions:
  - Both valid: grant `!last`.
  - Only one valid: grant that one.
  - Neither valid: stay in IDLE.
- Gx transitions, evaluated each cycle (x = granted requester, y = the other):
  - `!vx && vy`: go to Gy.
  - `!vx && !vy`: go to IDLE.
  - `vy` and (`cnt == MAX_BURST`, or `cnt == MAX_BURST-1` with a transfer this cycle): go to Gy.
  - Otherwise stay in Gx.
- `cnt` clears to 0 on every state change. It never exceeds `MAX_BURST`. Width is 4 bits.
- A requester may drop `vi` without a transfer. Arbitration re-evaluates the next cycle.
- The mux is driven only by `s`. Data from the non-granted input never reaches `o`.

## Timing
- Reset values (applied asynchronously, held while `rst_n` = 0):
  - state IDLE
  - `s` = 0
  - `o` = 0
  - `ov` = 0
  - `cnt` = 0
  - `last` = 1, so requester 0 wins the first contention
  - `r0` = `r1` = 0
- Latency:
  - Valid seen in IDLE at cycle n: grant at n+1, `ri` at n+1 if the slot is free, transfer at n+1, `ov` at n+2.
  - While a grant is held with `ordy` = 1 every cycle: one transfer per cycle.
- Grant switch costs zero idle cycles. Example: the transfer at cycle n triggers the switch, the new `s` takes effect at n+1, and the new requester can transfer at n+1.
- Downstream stall: if `ov && !ordy`, then `r0` = `r1` = 0, and `o`/`ov` are stable until `ordy`.
- Simultaneous drain and fill (`ov && ordy` plus a transfer): `ov` stays 1 and `o` takes the new word. No bubble.
- With `MAX_BURST` = 1 and both requesters valid continuously: strict alternation 0,1,0,1 per transfer.
- Reset asserted mid-burst: the output word is discarded and `ov` falls immediately. The requester sees `ri` = 0 and keeps its data.

## Structure
- Package `mux_arb_pkg`:
  - state encoding: IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10
  - data width constant `DW` = 32
  - `MAX_BURST` legality bound
- Sub-module: one instance of `MUX2T1_32`, with `I0`/`I1` → `.I0`/`.I1`, `s` → `.s`, internal `mux_o` → `.o`.
- Everything else lives in the top: state register, burst counter, pointer, output stage.

## Test plan
- Reset, then `v0` = 1 with `I0` = 32'h0000_00A5 and `ordy` = 1 → `r0` = 1 at cycle 1, `o` = 32'h0000_00A5 and `ov` = 1 at cycle 2, `s` = 0.
- Both valid from reset with `MAX_BURST` = 4, `I0` = 32'h0, `I1` = 32'hFFFF_FFFF, `ordy` = 1 → four words of 32'h0, then four of 32'hFFFF_FFFF, repeating; `s` toggles after every 4th transfer.
- `ordy` held at 0 for 3 cycles while `ov` = 1 → `o` stable, `r0` = `r1` = 0; on `ordy` = 1, `ov` stays 1 with the next word on the following edge (no bubble).
- In G0, `v0` falls while `v1` = 1 → G1 the next cycle, `s` = 1, `cnt` = 0.
- Pulse `rst_n` low mid-burst → `ov`, `o`, and `s` go to 0 asynchronously; after release, requester 0 wins the first contention.
- `MAX_BURST` = 1, both requesters valid for 6 transfers → sources 0,1,0,1,0,1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the two-requester mux arbiter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } arb_state_e;

  localparam int DW            = 32;
  localparam int CNT_W         = 4;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 15;

endpackage

// File: rtl/mux2t1_32_arb_if.sv
// rtl/mux2t1_32_arb_if.sv - requester, select and output-stage signals of the mux arbiter
interface mux2t1_32_arb_if;
  import mux_arb_pkg::*;

  logic [DW-1:0] I0;
  logic          v0;
  logic          r0;
  logic [DW-1:0] I1;
  logic          v1;
  logic          r1;
  logic          s;
  logic [DW-1:0] o;
  logic          ov;
  logic          ordy;

  modport slave (
    input  I0, v0, I1, v1, ordy,
    output r0, r1, s, o, ov
  );

  modport master (
    output I0, v0, I1, v1, ordy,
    input  r0, r1, s, o, ov
  );

endinterface

// File: rtl/MUX2T1_32.sv
// rtl/MUX2T1_32.sv - 32-bit 2:1 data multiplexer steered by the arbiter select
module MUX2T1_32
  import mux_arb_pkg::*;
(
  input  logic [DW-1:0] I0,
  input  logic [DW-1:0] I1,
  input  logic          s,
  output logic [DW-1:0] o
);

  assign o = s ? I1 : I0;

endmodule

// File: rtl/mux2t1_32_arb.sv
// rtl/mux2t1_32_arb.sv - round-robin grant of the shared 32-bit mux path with burst cap and output register
module mux2t1_32_arb
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
)
(
  input  logic            clk,
  input  logic            rst_n,
  mux2t1_32_arb_if.slave  bus
);

  // Out-of-range burst caps are clamped into the representable counter range.
  localparam int MB_INT = (MAX_BURST < MAX_BURST_MIN) ? MAX_BURST_MIN :
                          (MAX_BURST > MAX_BURST_MAX) ? MAX_BURST_MAX : MAX_BURST;
  localparam logic [CNT_W-1:0] MB    = CNT_W'(MB_INT);
  localparam logic [CNT_W-1:0] MB_M1 = CNT_W'(MB_INT - 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [DW-1:0]    mux_o;
  logic [DW-1:0]    o_reg;
  logic             ov_reg;
  logic             free;
  logic             r0;
  logic             r1;
  logic             xfer;
  logic             cap_hit;

  MUX2T1_32 u_mux (
    .I0 (bus.I0),
    .I1 (bus.I1),
    .s  (bus.s),
    .o  (mux_o)
  );

  assign free    = !ov_reg || bus.ordy;
  assign r0      = (state == G0) && free;
  assign r1      = (state == G1) && free;
  assign xfer    = (bus.v0 && r0) || (bus.v1 && r1);
  assign cap_hit = (cnt == MB) || ((cnt == MB_M1) && xfer);

  assign bus.r0 = r0;
  assign bus.r1 = r1;
  assign bus.s  = (state == G1);
  assign bus.o  = o_reg;
  assign bus.ov = ov_reg;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.v0 && bus.v1) state_nxt = last ? G0 : G1;
        else if (bus.v0)      state_nxt = G0;
        else if (bus.v1)      state_nxt = G1;
      end
      G0: begin
        if (!bus.v0)                state_nxt = bus.v1 ? G1 : IDLE;
        else if (bus.v1 && cap_hit) state_nxt = G1;
      end
      G1: begin
        if (!bus.v1)                state_nxt = bus.v0 ? G0 : IDLE;
        else if (bus.v0 && cap_hit) state_nxt = G0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
        if (state_nxt != IDLE) last <= (state_nxt == G1);
      end else if (xfer && (cnt != MB)) begin
        // Saturate so a lone requester can stream past the cap without wrapping.
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_reg  <= '0;
      ov_reg <= 1'b0;
    end else if (xfer) begin
      o_reg  <= mux_o;
      ov_reg <= 1'b1;
    end else if (ov_reg && bus.ordy) begin
      ov_reg <= 1'b0;
    end
  end

endmodule
